rle_pixel_decoder: RTL



---
 rtl/rle_pixel_decoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/rle_pixel_decoder.sv
// Run-length pixel decoder: turns {colour, run} instructions into one RGB222 pixel per active cycle.
// Optional saturating underrun pixel counter is enabled by defining RLE_UNDERRUN_COUNT_EN.
module rle_pixel_decoder #(
    parameter int COLOR_W = 6,
    parameter int RUN_W   = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COLOR_W+RUN_W-1:0] instr,
    input  logic                     instr_valid,
    output logic                     shift_data,
    input  logic                     video_active,
    input  logic                     frame_start,
    output logic [COLOR_W-1:0]       rgb,
    output logic                     underrun
`ifdef RLE_UNDERRUN_COUNT_EN
    ,
    output logic [15:0]              underrun_count
`endif
);

    logic               r_valid_d;
    logic               r_cur_full;
    logic [COLOR_W-1:0] r_cur_color;
    logic [RUN_W-1:0]   r_cur_cnt;
    logic               r_nxt_full;
    logic [COLOR_W-1:0] r_nxt_color;
    logic [RUN_W-1:0]   r_nxt_cnt;
    logic               r_held;
    logic               r_shift_data;
    logic [COLOR_W-1:0] r_rgb;
    logic               r_underrun;

    logic               w_capture;
    logic               w_underrun_evt;
    logic               w_cur_full;
    logic [COLOR_W-1:0] w_cur_color;
    logic [RUN_W-1:0]   w_cur_cnt;
    logic               w_nxt_full;
    logic [COLOR_W-1:0] w_nxt_color;
    logic [RUN_W-1:0]   w_nxt_cnt;
    logic               w_held;
    logic [COLOR_W-1:0] w_rgb;
    logic               w_underrun;
    logic [COLOR_W-1:0] w_in_color;
    logic [RUN_W-1:0]   w_in_cnt;

    assign w_in_color = instr[COLOR_W+RUN_W-1:RUN_W];
    assign w_in_cnt   = instr[RUN_W-1:0];

    // Pixel consumption first, then capture routing against the post-consume slot state.
    always_comb begin
        w_capture      = instr_valid & ~r_valid_d;
        w_underrun_evt = video_active & ~r_cur_full;
        w_cur_full     = r_cur_full;
        w_cur_color    = r_cur_color;
        w_cur_cnt      = r_cur_cnt;
        w_nxt_full     = r_nxt_full;
        w_nxt_color    = r_nxt_color;
        w_nxt_cnt      = r_nxt_cnt;
        w_held         = r_held;
        w_rgb          = '0;

        if (video_active && r_cur_full) begin
            w_rgb = r_cur_color;
            if (r_cur_cnt == '0) begin
                if (r_nxt_full) begin
                    w_cur_color = r_nxt_color;
                    w_cur_cnt   = r_nxt_cnt;
                    w_nxt_full  = 1'b0;
                end else begin
                    w_cur_full = 1'b0;
                end
            end else begin
                w_cur_cnt = r_cur_cnt - RUN_W'(1);
            end
        end else begin
            w_rgb = '0;
        end

        // A parked instruction stays on the bus because the reader is stalled.
        if (w_capture) begin
            if (!w_cur_full && !w_nxt_full) begin
                w_cur_full  = 1'b1;
                w_cur_color = w_in_color;
                w_cur_cnt   = w_in_cnt;
            end else if (!w_nxt_full) begin
                w_nxt_full  = 1'b1;
                w_nxt_color = w_in_color;
                w_nxt_cnt   = w_in_cnt;
            end else begin
                w_held = 1'b1;
            end
        end else if (r_held && !w_nxt_full) begin
            w_nxt_full  = 1'b1;
            w_nxt_color = w_in_color;
            w_nxt_cnt   = w_in_cnt;
            w_held      = 1'b0;
        end else begin
            w_held = r_held;
        end

        if (w_underrun_evt) begin
            w_underrun = 1'b1;
        end else if (frame_start) begin
            w_underrun = 1'b0;
        end else begin
            w_underrun = r_underrun;
        end
    end

    // State, slot and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid_d    <= 1'b0;
            r_cur_full   <= 1'b0;
            r_cur_color  <= '0;
            r_cur_cnt    <= '0;
            r_nxt_full   <= 1'b0;
            r_nxt_color  <= '0;
            r_nxt_cnt    <= '0;
            r_held       <= 1'b0;
            r_shift_data <= 1'b1;
            r_rgb        <= '0;
            r_underrun   <= 1'b0;
        end else begin
            r_valid_d    <= instr_valid;
            r_cur_full   <= w_cur_full;
            r_cur_color  <= w_cur_color;
            r_cur_cnt    <= w_cur_cnt;
            r_nxt_full   <= w_nxt_full;
            r_nxt_color  <= w_nxt_color;
            r_nxt_cnt    <= w_nxt_cnt;
            r_held       <= w_held;
            r_shift_data <= ~r_nxt_full & ~r_held;
            r_rgb        <= w_rgb;
            r_underrun   <= w_underrun;
        end
    end

    assign shift_data = r_shift_data;
    assign rgb        = r_rgb;
    assign underrun   = r_underrun;

`ifdef RLE_UNDERRUN_COUNT_EN
    logic [15:0] r_underrun_count;

    // Saturating count of underrun pixels; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_underrun_count <= 16'h0000;
        end else if (w_underrun_evt && (r_underrun_count != 16'hFFFF)) begin
            r_underrun_count <= r_underrun_count + 16'h0001;
        end else begin
            r_underrun_count <= r_underrun_count;
        end
    end

    assign underrun_count = r_underrun_count;
`endif

endmodule
